// File: rtl/irr_pkg.sv
// Shared phase and irrigation-type encodings for the sequencer and timer preset logic.
package irr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PREP     = 2'b01,
    ST_IRRIGATE = 2'b10,
    ST_REST     = 2'b11
  } phase_t;

  localparam logic [1:0] TYPE_OFF    = 2'b00;
  localparam logic [1:0] TYPE_SPRINK = 2'b01;
  localparam logic [1:0] TYPE_DRIP   = 2'b10;
  localparam logic [1:0] TYPE_BAD    = 2'b11;

  function automatic logic type_is_runnable(input logic [1:0] t);
    return (t == TYPE_SPRINK) || (t == TYPE_DRIP);
  endfunction

endpackage

// File: rtl/irr_watchdog.sv
// Per-phase cycle counter; flags expiry once a non-idle phase has lasted WDOG_CYCLES cycles.
module irr_watchdog #(
  parameter int WDOG_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam int W = $clog2(WDOG_CYCLES) + 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !active) begin
      cnt <= '0;
    end else if (cnt != W'(WDOG_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = active && (cnt == W'(WDOG_CYCLES));

endmodule

// File: rtl/irrigation_sequencer.sv
// Master irrigation FSM: IDLE -> PREP -> (IRRIGATE -> REST) x N -> IDLE, strobing the timer on each phase change.
// Optional per-phase watchdog enabled by defining IRR_WATCHDOG_EN.
module irrigation_sequencer
  import irr_pkg::*;
#(
  parameter int N_CYCLES    = 3,
  parameter int ARM_CYCLES  = 2,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] irr_type_in,
  input  logic       water_low,
  input  logic       timer_done,
  output logic [1:0] state,
  output logic [1:0] irrigation_type,
  output logic       pulse_transiction,
  output logic       init_pulse,
  output logic       pump_on,
  output logic       valve_on,
  output logic       busy,
  output logic       fault
);

  localparam int CW = 4;
  localparam int AW = (ARM_CYCLES < 1) ? 1 : $clog2(ARM_CYCLES + 1);

  phase_t        st_q, st_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [AW-1:0] arm_q;
  logic [1:0]    type_d;
  logic          fault_d, pump_d, valve_d, busy_d;
  logic          chg, done_armed, wdog_exp;

  // Timer presets take a few cycles to load; expiry seen before then is stale.
  assign done_armed = timer_done && (arm_q == '0);
  assign chg        = (st_d != st_q);

`ifdef IRR_WATCHDOG_EN
  irr_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (chg),
    .active  (st_q != ST_IDLE),
    .expired (wdog_exp)
  );
`else
  assign wdog_exp = 1'b0 & (WDOG_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q              <= ST_IDLE;
      cyc_q             <= CW'(N_CYCLES);
      arm_q             <= '0;
      irrigation_type   <= TYPE_OFF;
      pulse_transiction <= 1'b0;
      init_pulse        <= 1'b1;
      pump_on           <= 1'b0;
      valve_on          <= 1'b0;
      busy              <= 1'b0;
      fault             <= 1'b0;
    end else begin
      st_q              <= st_d;
      cyc_q             <= cyc_d;
      irrigation_type   <= type_d;
      pulse_transiction <= chg;
      init_pulse        <= 1'b0;
      pump_on           <= pump_d;
      valve_on          <= valve_d;
      busy              <= busy_d;
      fault             <= fault_d;
      if (chg) begin
        arm_q <= AW'(ARM_CYCLES);
      end else if (arm_q != '0) begin
        arm_q <= arm_q - 1'b1;
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    cyc_d   = cyc_q;
    type_d  = irrigation_type;
    fault_d = fault;
    if (stop) begin
      st_d = ST_IDLE;
    end else if (wdog_exp) begin
      st_d    = ST_IDLE;
      fault_d = 1'b1;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (start) begin
            if (type_is_runnable(irr_type_in) && !water_low) begin
              st_d    = ST_PREP;
              type_d  = irr_type_in;
              fault_d = 1'b0;
              cyc_d   = CW'(N_CYCLES);
            end else begin
              fault_d = 1'b1;
            end
          end
        end
        ST_PREP: begin
          if (done_armed) st_d = ST_IRRIGATE;
        end
        ST_IRRIGATE: begin
          if (water_low) begin
            st_d    = ST_IDLE;
            fault_d = 1'b1;
          end else if (done_armed) begin
            st_d  = ST_REST;
            cyc_d = cyc_q - 1'b1;
          end
        end
        default: begin
          if (done_armed) st_d = (cyc_q != '0) ? ST_IRRIGATE : ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pump_d  = (st_d == ST_PREP) || (st_d == ST_IRRIGATE);
    valve_d = (st_d == ST_IRRIGATE);
    busy_d  = (st_d != ST_IDLE);
  end

  assign state = st_q;

endmodule
